data_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and
//  the word-organised data_memory. It serves byte reads/writes from the CPU. On a miss it stalls
//  the CPU with busywait, writes back a dirty victim block, then refills the block with one
//  32-bit memory word.

---
 rtl/data_cache.sv | 155 +++++++++++++++
 tb/tb_data_cache.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 bytes, 3-bit tags.
// Byte-wide CPU side, one 32-bit word per block on the memory side.
module data_cache (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] data_arr [8];
    logic [2:0]  tag_arr  [8];
    logic [7:0]  valid;
    logic [7:0]  dirty;

    logic [2:0]  req_tag;
    logic [2:0]  index;
    logic [1:0]  offset;
    logic        request;
    logic        hit;
    logic        write_hit;
    logic        fetch_done;
    logic        wb_done;

    // Pick one byte out of a block word; byte n lives on bits [8n+7:8n].
    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    assign req_tag = address[7:5];
    assign index   = address[4:2];
    assign offset  = address[1:0];
    assign request = read | write;

    // Lookup, CPU-facing outputs and the store-hit strobe.
    always_comb begin
        hit       = valid[index] & (tag_arr[index] == req_tag);
        write_hit = write & (state == IDLE) & hit;
        // Gated by reset so the CPU is never stalled while the cache is held in reset.
        busywait  = reset & request & ~((state == IDLE) & hit);
        if (read) begin
            readdata = select_byte(data_arr[index], offset);
        end else begin
            readdata = 8'h00;
        end
    end

    // Next-state logic and memory-side outputs of the miss-handling FSM.
    always_comb begin
        next_state    = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = {req_tag, index};
        mem_writedata = data_arr[index];
        fetch_done    = 1'b0;
        wb_done       = 1'b0;
        case (state)
            IDLE: begin
                if (request && !hit) begin
                    if (valid[index] && dirty[index]) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FETCH;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {tag_arr[index], index};
                if (!mem_busywait) begin
                    wb_done = 1'b1;
                    // A request dropped mid-writeback ends the miss here.
                    if (request) begin
                        next_state = FETCH;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_state = WRITEBACK;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    fetch_done = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM state plus valid/dirty bookkeeping; reset invalidates every line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            valid <= 8'h00;
            dirty <= 8'h00;
        end else begin
            state <= next_state;
            if (fetch_done) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end else if (wb_done) begin
                dirty[index] <= 1'b0;
            end else if (write_hit) begin
                dirty[index] <= 1'b1;
            end
        end
    end

    // Data and tag storage; not cleared by reset, but frozen while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (fetch_done) begin
                data_arr[index] <= mem_readdata;
                tag_arr[index]  <= req_tag;
            end else if (write_hit) begin
                data_arr[index][{offset, 3'b000} +: 8] <= writedata;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a small word-memory model that holds
// mem_busywait high for two cycles per transfer.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int          total = 0;
    int          bad   = 0;

    logic [31:0] wmem [64];
    logic [63:0] written      = 64'h0;
    int          wait_cnt     = 0;
    int          wr_count     = 0;
    int          rd_count     = 0;
    logic [5:0]  last_wr_addr = 6'h00;
    logic [31:0] last_wr_data = 32'h0;
    logic [5:0]  last_rd_addr = 6'h00;
    logic        overlap_seen = 1'b0;

    logic [7:0]  rdata;
    int          stalls;
    int          wr0;
    int          rd0;

    always #5 clk = ~clk;

    data_cache dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    // Power-on memory contents: a few fixed words, the rest derived from the word address.
    function automatic logic [31:0] init_word(input logic [5:0] a);
        logic [31:0] w;
        case (a)
            6'd1:    w = 32'h44332211;
            6'd4:    w = 32'h0F0E0D0C;
            6'd9:    w = 32'h99887766;
            6'd17:   w = 32'hDDCCBBAA;
            default: w = {2'b00, a, 2'b01, a, 2'b10, a, 2'b11, a};
        endcase
        return w;
    endfunction

    assign mem_readdata = written[mem_address] ? wmem[mem_address] : init_word(mem_address);
    assign mem_busywait = (mem_read | mem_write) && (wait_cnt != 2);

    // Memory model: complete a transfer on the third cycle of a request and log it.
    always @(posedge clk) begin
        if (mem_read || mem_write) begin
            if (wait_cnt == 2) begin
                wait_cnt <= 0;
                if (mem_write) begin
                    wmem[mem_address]    <= mem_writedata;
                    written[mem_address] <= 1'b1;
                    wr_count             <= wr_count + 1;
                    last_wr_addr         <= mem_address;
                    last_wr_data         <= mem_writedata;
                end else begin
                    rd_count     <= rd_count + 1;
                    last_rd_addr <= mem_address;
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // Flag any cycle where both memory strobes are high.
    always @(negedge clk) begin
        if (mem_read && mem_write) overlap_seen <= 1'b1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One CPU access held until busywait falls; returns the byte read and the stall count.
    task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wd, output logic [7:0] data_out,
                              output int stall_out);
        @(negedge clk);
        read      = rd;
        write     = wr;
        address   = addr;
        writedata = wd;
        #1;
        stall_out = 0;
        while (busywait && stall_out < 40) begin
            @(negedge clk);
            #1;
            stall_out++;
        end
        if (busywait) check_value("access_timeout", 32'(busywait), 32'd0);
        data_out = readdata;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = 8'h00;
        writedata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_busywait", 32'(busywait), 32'd0);
        check_value("rst_mem_read", 32'(mem_read), 32'd0);
        check_value("rst_mem_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Test 1: cold read miss of 0x05.
        @(negedge clk);
        read    = 1'b1;
        address = 8'h05;
        #1;
        check_value("t1_busy_start", 32'(busywait), 32'd1);
        @(negedge clk);
        #1;
        check_value("t1_mem_read", 32'(mem_read), 32'd1);
        check_value("t1_mem_write", 32'(mem_write), 32'd0);
        check_value("t1_mem_addr", 32'(mem_address), 32'h01);
        stalls = 0;
        while (busywait && stalls < 40) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        check_value("t1_busy_end", 32'(busywait), 32'd0);
        check_value("t1_readdata", 32'(readdata), 32'h22);
        check_value("t1_rd_count", 32'(rd_count), 32'd1);
        @(posedge clk);
        #1;
        read = 1'b0;
        #1;
        check_value("t1_rdata_idle", 32'(readdata), 32'h00);

        // Test 2: write hit then read back.
        wr0 = wr_count;
        rd0 = rd_count;
        cpu_access(1'b0, 1'b1, 8'h04, 8'hAB, rdata, stalls);
        check_value("t2_wr_stalls", 32'(stalls), 32'd0);
        cpu_access(1'b1, 1'b0, 8'h04, 8'h00, rdata, stalls);
        check_value("t2_rd_stalls", 32'(stalls), 32'd0);
        check_value("t2_readdata", 32'(rdata), 32'hAB);
        check_value("t2_no_wb", 32'(wr_count - wr0), 32'd0);
        check_value("t2_no_fetch", 32'(rd_count - rd0), 32'd0);

        // Test 3: dirty eviction of index 1.
        wr0 = wr_count;
        rd0 = rd_count;
        cpu_access(1'b1, 1'b0, 8'h24, 8'h00, rdata, stalls);
        check_value("t3_wb_count", 32'(wr_count - wr0), 32'd1);
        check_value("t3_wb_addr", 32'(last_wr_addr), 32'h01);
        check_value("t3_wb_data", last_wr_data, 32'h443322AB);
        check_value("t3_fetch_addr", 32'(last_rd_addr), 32'h09);
        check_value("t3_readdata", 32'(rdata), 32'h66);

        // Test 4: clean eviction, then a plain hit.
        wr0 = wr_count;
        rd0 = rd_count;
        cpu_access(1'b1, 1'b0, 8'h44, 8'h00, rdata, stalls);
        check_value("t4_no_wb", 32'(wr_count - wr0), 32'd0);
        check_value("t4_fetch_count", 32'(rd_count - rd0), 32'd1);
        check_value("t4_fetch_addr", 32'(last_rd_addr), 32'h11);
        check_value("t4_readdata", 32'(rdata), 32'hAA);
        cpu_access(1'b1, 1'b0, 8'h45, 8'h00, rdata, stalls);
        check_value("t4_hit_stalls", 32'(stalls), 32'd0);
        check_value("t4_hit_data", 32'(rdata), 32'hBB);

        // Test 5: store miss allocates, then the dirty line is evicted.
        wr0 = wr_count;
        rd0 = rd_count;
        cpu_access(1'b0, 1'b1, 8'h10, 8'h7F, rdata, stalls);
        check_value("t5_fetch_addr", 32'(last_rd_addr), 32'h04);
        check_value("t5_no_wb", 32'(wr_count - wr0), 32'd0);
        cpu_access(1'b1, 1'b0, 8'h10, 8'h00, rdata, stalls);
        check_value("t5_readback", 32'(rdata), 32'h7F);
        check_value("t5_rb_stalls", 32'(stalls), 32'd0);
        cpu_access(1'b1, 1'b0, 8'h30, 8'h00, rdata, stalls);
        check_value("t5_wb_addr", 32'(last_wr_addr), 32'h04);
        check_value("t5_wb_data", last_wr_data, 32'h0F0E0D7F);
        check_value("t5_fetch2_addr", 32'(last_rd_addr), 32'h0C);
        check_value("t5_readdata", 32'(rdata), 32'hCC);

        // Test 6: reset during FETCH abandons the refill.
        rd0 = rd_count;
        @(negedge clk);
        read    = 1'b1;
        address = 8'h08;
        @(negedge clk);
        #1;
        check_value("t6_in_fetch", 32'(mem_read), 32'd1);
        reset = 1'b0;
        #1;
        check_value("t6_mem_read_drop", 32'(mem_read), 32'd0);
        check_value("t6_busy_drop", 32'(busywait), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        read  = 1'b0;
        check_value("t6_no_refill", 32'(rd_count - rd0), 32'd0);
        cpu_access(1'b1, 1'b0, 8'h08, 8'h00, rdata, stalls);
        check_value("t6_miss_again", 32'(rd_count - rd0), 32'd1);
        check_value("t6_fetch_addr", 32'(last_rd_addr), 32'h02);
        check_value("t6_readdata", 32'(rdata), 32'hC2);

        check_value("no_overlap", 32'(overlap_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
